// File: rtl/dds_wavegen.sv
// dds_wavegen: direct-digital-synthesis waveform generator.
// A phase accumulator drives a quarter-wave sine ROM and computed triangle,
// sawtooth and square shapes. Waveform mode switches only at period wraps.
// Optional build macro DDS_AMPLITUDE_EN adds an 8-bit amplitude input and a
// scaling stage around mid-scale (pipeline latency grows from 2 to 3).

// memory: quarter-wave sine ROM with registered read; en low holds the output.
module memory #(
   parameter int    ADDR_BITS  = 7,
   parameter int    DATA_WIDTH = 9,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [ADDR_BITS-1:0]  addr,
   output logic [DATA_WIDTH-1:0] data
);
   localparam int DEPTH = 2**ADDR_BITS;

   // Entry i = round((2**DATA_WIDTH-1) * sin(pi/2 * i/DEPTH)), evaluated at elaboration.
   function automatic int sine_entry(input int i);
      real x, term, acc;
      x    = 1.5707963267948966 * real'(i) / real'(DEPTH);
      term = x;
      acc  = x;
      for (int k = 1; k <= 10; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      return $rtoi(acc * real'((2**DATA_WIDTH) - 1) + 0.5);
   endfunction

   logic [DATA_WIDTH-1:0] rom [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
         localparam int ENTRY = sine_entry(gi);
         assign rom[gi] = ENTRY[DATA_WIDTH-1:0];
      end
      if (INIT_FILE != "") begin : g_init_file
         $error("memory: table is computed internally; INIT_FILE must be left empty");
      end
   endgenerate

   // Registered ROM read, held while the pipeline is stalled.
   always_ff @(posedge clk) begin
      if (en) data <= rom[addr];
   end
endmodule

module dds_wavegen #(
   parameter int    PHASE_WIDTH    = 16,
   parameter int    LUT_ADDR_BITS  = 7,
   parameter int    LUT_DATA_WIDTH = 9,
   parameter int    OUT_WIDTH      = 10,
   parameter string SINE_PATH      = ""
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [PHASE_WIDTH-1:0] tuning_word,
   input  logic [1:0]             mode,
`ifdef DDS_AMPLITUDE_EN
   input  logic [7:0]             amplitude,
`endif
   output logic [OUT_WIDTH-1:0]   out,
   output logic                   out_valid,
   output logic                   period_start
);
   localparam int TOPW = OUT_WIDTH + 1;
   localparam int AW   = OUT_WIDTH + 2;
   localparam logic [OUT_WIDTH-1:0]     MID    = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [OUT_WIDTH-1:0]     MID_M1 = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]     FULL   = '1;
   localparam logic [OUT_WIDTH-1:0]     ONE    = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [LUT_ADDR_BITS-1:0] MAXI   = '1;

   generate
      if (PHASE_WIDTH < LUT_ADDR_BITS + 2 || PHASE_WIDTH < OUT_WIDTH + 1 ||
          LUT_DATA_WIDTH > OUT_WIDTH - 1) begin : g_bad_params
         $error("dds_wavegen: inconsistent width parameters");
      end
   endgenerate

   // ---------------- stage 0: phase accumulator ----------------
   logic [PHASE_WIDTH-1:0] phase_reg;
   logic [1:0]             active_mode_reg;
   logic                   wrap_reg;
   logic [PHASE_WIDTH:0]   phase_sum;

   assign phase_sum = {1'b0, phase_reg} + {1'b0, tuning_word};

   // Advance phase; the carry-out marks a new period and latches the requested mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_reg       <= '0;
         active_mode_reg <= 2'd0;
         wrap_reg        <= 1'b0;
      end else if (en) begin
         phase_reg <= phase_sum[PHASE_WIDTH-1:0];
         wrap_reg  <= phase_sum[PHASE_WIDTH];
         if (phase_sum[PHASE_WIDTH]) active_mode_reg <= mode;
      end
   end

   // ---------------- stage 1: ROM address and context ----------------
   logic [1:0]               quad0;
   logic [LUT_ADDR_BITS-1:0] idx0, lut_addr;
   logic [LUT_DATA_WIDTH-1:0] lut_data;
   logic [TOPW-1:0]          top1_reg;
   logic [1:0]               mode1_reg;
   logic                     wrap1_reg, v1_reg;

   assign quad0    = phase_reg[PHASE_WIDTH-1 -: 2];
   assign idx0     = phase_reg[PHASE_WIDTH-3 -: LUT_ADDR_BITS];
   assign lut_addr = quad0[0] ? (MAXI - idx0) : idx0;

   memory #(
      .ADDR_BITS  (LUT_ADDR_BITS),
      .DATA_WIDTH (LUT_DATA_WIDTH),
      .INIT_FILE  (SINE_PATH)
   ) u_sine_rom (
      .clk  (clk),
      .en   (en),
      .addr (lut_addr),
      .data (lut_data)
   );

   // Carry phase top bits, mode and wrap alongside the ROM read so they arrive together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top1_reg  <= '0;
         mode1_reg <= 2'd0;
         wrap1_reg <= 1'b0;
         v1_reg    <= 1'b0;
      end else if (en) begin
         top1_reg  <= phase_reg[PHASE_WIDTH-1 -: TOPW];
         mode1_reg <= active_mode_reg;
         wrap1_reg <= wrap_reg;
         v1_reg    <= 1'b1;
      end
   end

   // ---------------- stage 2: waveform shaping ----------------
   logic [1:0]           quad1;
   logic [OUT_WIDTH-1:0] lut_ext, wave_next;
   logic [AW-1:0]        r_a, rm_a, tri_a;

   assign quad1   = top1_reg[OUT_WIDTH -: 2];
   assign lut_ext = OUT_WIDTH'(lut_data);

   // Select the sample for the active mode; triangle is clamped into [1, FULL].
   always_comb begin
      r_a  = AW'(top1_reg[OUT_WIDTH-2:0]);
      rm_a = AW'(MID_M1) - r_a;
      case (quad1)
         2'd0:    tri_a = AW'(MID) + r_a;
         2'd1:    tri_a = AW'(MID) + rm_a;
         2'd2:    tri_a = AW'(MID) - r_a;
         default: tri_a = AW'(MID) - rm_a;
      endcase
      wave_next = MID;
      case (mode1_reg)
         2'd0: wave_next = quad1[1] ? (MID - lut_ext) : (MID + lut_ext);
         2'd1: begin
            if (tri_a[AW-1] || tri_a == '0) wave_next = ONE;
            else if (tri_a[AW-2])            wave_next = FULL;
            else                             wave_next = tri_a[OUT_WIDTH-1:0];
         end
         2'd2:    wave_next = top1_reg[OUT_WIDTH:1];
         default: wave_next = quad1[1] ? '0 : FULL;
      endcase
   end

`ifdef DDS_AMPLITUDE_EN
   logic [OUT_WIDTH-1:0]   raw2_reg, dev, scaled, scaled_next;
   logic [1:0]             mode2_reg;
   logic                   wrap2_reg, v2_reg, up;
   logic [OUT_WIDTH+7:0]   prod;
   logic [OUT_WIDTH-1:0]   out_reg;
   logic                   out_valid_reg, period_start_reg;

   // Register the full-scale sample and its context for the scaling stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw2_reg  <= MID;
         mode2_reg <= 2'd0;
         wrap2_reg <= 1'b0;
         v2_reg    <= 1'b0;
      end else if (en) begin
         raw2_reg  <= wave_next;
         mode2_reg <= mode1_reg;
         wrap2_reg <= wrap1_reg;
         v2_reg    <= v1_reg;
      end
   end

   // Scale the deviation from mid-scale by amplitude/256; square uses a fixed deviation.
   always_comb begin
      if (mode2_reg == 2'd3) begin
         up  = raw2_reg[OUT_WIDTH-1];
         dev = MID_M1;
      end else begin
         up  = (raw2_reg >= MID);
         dev = up ? (raw2_reg - MID) : (MID - raw2_reg);
      end
      prod        = (OUT_WIDTH+8)'(dev) * (OUT_WIDTH+8)'(amplitude);
      scaled      = prod[OUT_WIDTH+7:8];
      scaled_next = up ? (MID + scaled) : (MID - scaled);
   end

   // Output register: sample, sticky valid, and a period pulse that is dropped while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg          <= MID;
         out_valid_reg    <= 1'b0;
         period_start_reg <= 1'b0;
      end else begin
         period_start_reg <= 1'b0;
         if (en) begin
            if (v2_reg) out_reg <= scaled_next;
            out_valid_reg    <= out_valid_reg | v2_reg;
            period_start_reg <= v2_reg & wrap2_reg;
         end
      end
   end
`else
   logic [OUT_WIDTH-1:0] out_reg;
   logic                 out_valid_reg, period_start_reg;

   // Output register: sample, sticky valid, and a period pulse that is dropped while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg          <= MID;
         out_valid_reg    <= 1'b0;
         period_start_reg <= 1'b0;
      end else begin
         period_start_reg <= 1'b0;
         if (en) begin
            if (v1_reg) out_reg <= wave_next;
            out_valid_reg    <= out_valid_reg | v1_reg;
            period_start_reg <= v1_reg & wrap1_reg;
         end
      end
   end
`endif

   assign out          = out_reg;
   assign out_valid    = out_valid_reg;
   assign period_start = period_start_reg;
endmodule

// File: tb/tb_dds_wavegen.sv
// tb_dds_wavegen: directed + random stimulus for dds_wavegen, checked against a
// behavioural model that computes each sample from the phase with plain arithmetic.
module tb_dds_wavegen;
   localparam int MID = 512;
`ifdef DDS_AMPLITUDE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] tuning_word;
   logic [1:0]  mode;
`ifdef DDS_AMPLITUDE_EN
   logic [7:0]  amplitude;
`endif
   wire  [9:0]  out;
   wire         out_valid;
   wire         period_start;

   always #5 clk = ~clk;

   dds_wavegen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .tuning_word  (tuning_word),
      .mode         (mode),
`ifdef DDS_AMPLITUDE_EN
      .amplitude    (amplitude),
`endif
      .out          (out),
      .out_valid    (out_valid),
      .period_start (period_start)
   );

   typedef struct {
      int val;
      int md;
      bit ps;
   } sample_t;

   sample_t hist[$];
   int      m_phase;
   int      m_mode;
   bit      m_wrap;
   int      exp_out;
   bit      exp_valid;
   bit      exp_ps;
   int      total = 0;
   int      bad   = 0;
   int      cyc   = 0;

   function automatic int lut_val(input int i);
      real a;
      a = 1.5707963267948966 * real'(i) / 128.0;
      return $rtoi($floor(511.0 * $sin(a) + 0.5));
   endfunction

   // Full-scale sample for phase p in mode md.
   function automatic int wave(input int p, input int md);
      int q, i, r, v;
      q = p / 16384;
      v = MID;
      case (md)
         0: begin
            i = (p / 128) % 128;
            if (q == 1 || q == 3) i = 127 - i;
            v = (q < 2) ? MID + lut_val(i) : MID - lut_val(i);
         end
         1: begin
            r = (p / 32) % 512;
            case (q)
               0:       v = MID + r;
               1:       v = MID + (511 - r);
               2:       v = MID - r;
               default: v = MID - (511 - r);
            endcase
            if (v < 1)    v = 1;
            if (v > 1023) v = 1023;
         end
         2:       v = p / 64;
         default: v = (q < 2) ? 1023 : 0;
      endcase
      return v;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_phase   = 0;
      m_mode    = 0;
      m_wrap    = 1'b0;
      exp_out   = MID;
      exp_valid = 1'b0;
      exp_ps    = 1'b0;
   endtask

   task automatic model_edge();
      sample_t s;
      int      sum;
      if (!en) begin
         exp_ps = 1'b0;
         return;
      end
      hist.push_back('{wave(m_phase, m_mode), m_mode, m_wrap});
      sum    = m_phase + int'(tuning_word);
      m_wrap = (sum >= 65536);
      if (m_wrap) m_mode = int'(mode);
      m_phase = sum % 65536;
      if (hist.size() >= LAT) begin
         s = hist[hist.size() - LAT];
`ifdef DDS_AMPLITUDE_EN
         begin : scale_blk
            int dev;
            bit up;
            if (s.md == 3) begin
               up  = (s.val == 1023);
               dev = MID - 1;
            end else begin
               up  = (s.val >= MID);
               dev = up ? s.val - MID : MID - s.val;
            end
            dev     = (dev * int'(amplitude)) / 256;
            exp_out = up ? MID + dev : MID - dev;
         end
`else
         exp_out = s.val;
`endif
         exp_valid = 1'b1;
         exp_ps    = s.ps;
      end else begin
         exp_ps = 1'b0;
      end
      while (hist.size() > 8) void'(hist.pop_front());
   endtask

   task automatic check(input string tag);
      total++;
      assert (out === 10'(exp_out)) else begin
         bad++;
         $error("FAIL %s out cycle=%0d got=%0d want=%0d", tag, cyc, out, exp_out);
      end
      total++;
      assert (out_valid === exp_valid) else begin
         bad++;
         $error("FAIL %s out_valid cycle=%0d got=%0b want=%0b", tag, cyc, out_valid, exp_valid);
      end
      total++;
      assert (period_start === exp_ps) else begin
         bad++;
         $error("FAIL %s period_start cycle=%0d got=%0b want=%0b", tag, cyc, period_start, exp_ps);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      cyc++;
      if (rst_n) model_edge();
      #1;
      check(tag);
   endtask

   initial begin
      rst_n       = 1'b0;
      en          = 1'b0;
      tuning_word = 16'h0000;
      mode        = 2'd0;
`ifdef DDS_AMPLITUDE_EN
      amplitude   = 8'd128;
`endif
      model_reset();
      #12;
      check("reset");

      // Sine, two full periods.
      rst_n       = 1'b1;
      en          = 1'b1;
      tuning_word = 16'h0080;
      repeat (1100) tick("sine");

      // Sawtooth takes over at the next wrap.
      mode        = 2'd2;
      tuning_word = 16'h0100;
      repeat (600) tick("saw");

      // Square, then a mid-period switch back to sine.
      mode        = 2'd3;
      tuning_word = 16'h0400;
      repeat (200) tick("square");
      repeat (20) tick("square_pre_switch");
      mode = 2'd0;
      repeat (150) tick("square_to_sine");

      // Stall in the middle of a sine period.
      tuning_word = 16'h0080;
      repeat (300) tick("sine_run");
      en = 1'b0;
      repeat (5) tick("stall");
      en = 1'b1;
      repeat (40) tick("resume");

      // Asynchronous reset between clock edges.
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_reset");
      repeat (2) tick("in_reset");
      #2;
      rst_n = 1'b1;
      repeat (20) tick("refill");

      // Randomised run: tuning word, mode, enable and amplitude.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 3))
               0:       tuning_word = 16'h0000;
               1:       tuning_word = 16'($urandom_range(32768, 65535));
               default: tuning_word = 16'($urandom_range(1, 2048));
            endcase
         end
         if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
         en = ($urandom_range(0, 7) != 0);
`ifdef DDS_AMPLITUDE_EN
         if ($urandom_range(0, 49) == 0) amplitude = 8'($urandom_range(0, 255));
`endif
         tick("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
